// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions a raw mechanical push-button into a clean debounced level plus
// one-cycle event pulses for press, release, long-press and (optionally)
// auto-repeat while the button stays held past the long-press point.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed before a level change is accepted (>= 2)
//   LONG_CYCLES      cycles after an accepted press until the long-press event
//                    (> DEBOUNCE_CYCLES)
//   REPEAT_CYCLES    auto-repeat period in cycles (>= 2)
//
// Ports:
//   clk            system clock, all state on its rising edge
//   rst            synchronous active-high reset
//   btn_raw        asynchronous raw button level, 1 = pressed
//   level          debounced button state
//   press_pulse    one-cycle pulse in the cycle level has just risen
//   release_pulse  one-cycle pulse in the cycle level has just fallen
//   long_pulse     one-cycle pulse once a press has been held LONG_CYCLES
//   repeat_pulse   one-cycle periodic pulse while held past the long press
//
// Configuration macro:
//   BTN_AUTOREPEAT_EN  when defined, builds the repeat counter and drives
//                      repeat_pulse; when undefined repeat_pulse is tied to 0.
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CYCLES);

    // Elaboration-time guards on illegal parameter combinations.
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("button_conditioner: LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 2) begin : g_bad_repeat
        $error("button_conditioner: REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,   // level low
        ST_PRESSED = 2'd1,   // level high, hold counter running
        ST_HELD    = 2'd2    // long press already reported
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer: btn_raw is asynchronous, so only the second flop
    // is allowed to feed any downstream logic.
    // -------------------------------------------------------------------------
    logic sync1_q;
    logic sync2_q;
    logic btn_sync;

    assign btn_sync = sync2_q;

    // -------------------------------------------------------------------------
    // Debounce: count consecutive cycles where the synchronized input disagrees
    // with the accepted level; once DEBOUNCE_CYCLES disagreeing cycles have
    // accumulated and the input still disagrees, flip the level.
    // -------------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            rise;
    logic            fall;

    // NOTE: every variable assigned in an always_comb gets a default on the
    // first lines, so no path can leave it unassigned and infer a latch.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (btn_sync == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
            level_d  = btn_sync;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // -------------------------------------------------------------------------
    // Press-tracking FSM. Release is checked before long-press expiry so that a
    // release landing on the expiry edge suppresses the long pulse.
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                long_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        long_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                if (rise) begin
                    state_d = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else if (hold_q >= HOLD_LAST) begin
                    state_d = ST_HELD;
                    hold_d  = HOLD_SAT;   // parks at the limit, never wraps
                    long_d  = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    logic press_q;
    logic release_q;
    logic long_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            state_q   <= state_d;
            hold_q    <= hold_d;
            press_q   <= rise;
            release_q <= fall;
            long_q    <= long_d;
        end
    end

    assign level         = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

    // -------------------------------------------------------------------------
    // Auto-repeat: restarts from zero on entry to HELD, fires every
    // REPEAT_CYCLES edges while held; a release on a repeat edge wins.
    // -------------------------------------------------------------------------
`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             repeat_q, repeat_d;

    always_comb begin
        rep_cnt_d = '0;
        repeat_d  = 1'b0;
        if (state_q == ST_HELD && !fall) begin
            if (rep_cnt_q >= REP_LAST) begin
                repeat_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
            repeat_q  <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            repeat_q  <= repeat_d;
        end
    end

    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, stable-input cycles required to accept a level change (10 ms at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000, cycles after accepted press before long-press event; SHALL be > DEBOUNCE_CYCLES.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 10000000, auto-repeat period in cycles; legal range >= 2.
REQ-004 SHALL have port clk, input, 1, 100 MHz system clock; all state on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port btn_raw, input, 1, asynchronous raw push-button level, 1 = pressed.
REQ-007 SHALL have port level, output, 1, debounced button state.
REQ-008 SHALL have port press_pulse, output, 1, one-cycle pulse on accepted press.
REQ-009 SHALL have port release_pulse, output, 1, one-cycle pulse on accepted release.
REQ-010 SHALL have port long_pulse, output, 1, one-cycle pulse when press held LONG_CYCLES.
REQ-011 SHALL have port repeat_pulse, output, 1, one-cycle periodic pulse while held past long-press.

Function
REQ-012 btn_raw SHALL pass a two-flop synchronizer; only the second flop output (btn_sync) SHALL be used downstream.
REQ-013 Debounce counter SHALL increment each cycle btn_sync != level and clear to 0 any cycle btn_sync == level.
REQ-014 level SHALL toggle on the edge where btn_sync has differed from level for DEBOUNCE_CYCLES consecutive cycles; counter clears on that edge.
REQ-015 Total latency: level changes exactly 2 + DEBOUNCE_CYCLES edges after the first edge sampling a new, stable btn_raw value.
REQ-016 Any btn_raw excursion shorter than DEBOUNCE_CYCLES cycles (after sync) SHALL produce no level change and no pulse.
REQ-017 press_pulse/release_pulse SHALL be registered, high for exactly the one cycle in which level has just risen/fallen.
REQ-018 FSM states: IDLE (level 0), PRESSED (level 1, hold counter running), HELD (long-press reached).
REQ-019 IDLE -> PRESSED on accepted press; hold counter cleared on entry.
REQ-020 PRESSED -> HELD when hold counter reaches LONG_CYCLES; long_pulse high exactly LONG_CYCLES edges after the press_pulse cycle.
REQ-021 PRESSED or HELD -> IDLE on accepted release; hold and repeat counters clear.
REQ-022 If release acceptance and long-press expiry fall on the same edge, release SHALL win: release_pulse asserted, long_pulse not asserted.
REQ-023 At most one long_pulse per press; pulses SHALL never coincide with each other.
REQ-024 Counter widths SHALL be $clog2 of their parameter + 1; counters SHALL saturate, never wrap.

Reset
REQ-025 While rst is high: synchronizer flops, level, all pulses, all counters = 0; FSM = IDLE.
REQ-026 rst asserted mid-press SHALL abort with no release_pulse; if btn_raw still pressed after rst drops, a fresh press_pulse SHALL follow after 2 + DEBOUNCE_CYCLES edges.

Configuration
REQ-027 Macro BTN_AUTOREPEAT_EN SHALL gate auto-repeat.
REQ-028 With BTN_AUTOREPEAT_EN defined: in HELD, repeat_pulse SHALL assert every REPEAT_CYCLES edges, first one REPEAT_CYCLES edges after long_pulse, until release.
REQ-029 Without BTN_AUTOREPEAT_EN: repeat_pulse SHALL be constant 0, no repeat counter synthesized; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5)
REQ-030 Clean press, btn_raw 0->1 sampled at edge 0 -> level and press_pulse high after edge 6; press_pulse low after edge 7.
REQ-031 Bounce, btn_raw high 3 cycles then low -> level stays 0, no pulses; then high 10 cycles -> single press_pulse.
REQ-032 Hold 40 cycles past press, BTN_AUTOREPEAT_EN defined -> long_pulse 20 edges after press_pulse, repeat_pulse at +25, +30, +35, +40; without macro -> repeat_pulse never high.
REQ-033 Release timed so release acceptance and long expiry fall on the same edge -> release_pulse only, no long_pulse.
REQ-034 rst pulsed 1 cycle while in HELD with btn_raw held -> all outputs 0 next cycle, no release_pulse, new press_pulse 6 edges after rst drops.
